// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package seg7_pkg;

  // Segment and anode idle patterns (active-low, so all ones means dark).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Index of one of the four digits, 0 = rightmost.
  typedef logic [1:0] dig_idx_t;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n is the glyph for hex nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex-nibble to active-low segment decoder.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup; the table already holds active-low patterns.
  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with per-slot ghost blanking,
// frame-synchronous (tear-free) display updates and leading-zero suppression.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] DIN,
  input  logic [3:0]  DP_IN,
  input  logic        BLANK_LZ,
  output logic [6:0]  nSEG,
  output logic        nDP,
  output logic [3:0]  nDIG
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  // Stage p0: timing counters and the frame-stable display image.
  logic [CNT_W-1:0] cnt_p0;
  dig_idx_t         scan_p0;
  logic [15:0]      disp_nib_p0;
  logic [3:0]       disp_dp_p0;

  logic [15:0]      pend_nib;
  logic [3:0]       pend_dp;
  logic             pend_vld;

  logic             tick;
  logic             frame_end;

  assign tick      = (cnt_p0 == CNT_LAST);
  assign frame_end = tick && (scan_p0 == 2'd3);

  // Prescaler wraps every CLK_DIV clocks; the scan index steps once per wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0  <= '0;
      scan_p0 <= '0;
    end else begin
      cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
      if (tick) begin
        scan_p0 <= scan_p0 + 1'b1;
      end
    end
  end

  // Pending data is only meaningful while pend_vld is set, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (!RST && LOAD && !frame_end) begin
      pend_nib <= DIN;
      pend_dp  <= DP_IN;
    end
  end

  // Display image changes only at the frame boundary; a load on that very tick bypasses pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp_nib_p0 <= '0;
      disp_dp_p0  <= '0;
      pend_vld    <= 1'b0;
    end else if (frame_end) begin
      pend_vld <= 1'b0;
      if (LOAD) begin
        disp_nib_p0 <= DIN;
        disp_dp_p0  <= DP_IN;
      end else if (pend_vld) begin
        disp_nib_p0 <= pend_nib;
        disp_dp_p0  <= pend_dp;
      end
    end else if (LOAD) begin
      pend_vld <= 1'b1;
    end
  end

  logic [3:0] sel_nib;
  logic       lz_zero;
  logic [6:0] dec_seg;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] dig_nxt;

  seg7_dec u_dec (
    .nib (sel_nib),
    .seg (dec_seg)
  );

  // Select the current digit and decide whether it falls in a run of leading zeros.
  always_comb begin
    sel_nib = disp_nib_p0[{scan_p0, 2'b00} +: 4];
    lz_zero = 1'b0;
    case (scan_p0)
      2'd3:    lz_zero = (disp_nib_p0[15:12] == 4'h0);
      2'd2:    lz_zero = (disp_nib_p0[15:8]  == 8'h00);
      2'd1:    lz_zero = (disp_nib_p0[15:4]  == 12'h000);
      default: lz_zero = 1'b0;
    endcase
  end

  // Compose the next output pattern: dark during the slot lead-in, else the selected digit.
  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    dig_nxt = DIG_OFF;
    if (cnt_p0 >= BLANK_END) begin
      dig_nxt = ~(4'b0001 << scan_p0);
      dp_nxt  = ~disp_dp_p0[scan_p0];
      seg_nxt = (BLANK_LZ && lz_zero) ? SEG_OFF : dec_seg;
    end
  end

  // Stage p1: registered pad drivers, one clock behind the counters and display image.
  logic [6:0] seg_p1;
  logic       dp_p1;
  logic [3:0] dig_p1;

  // Output register forces every pad dark while in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b1;
      dig_p1 <= DIG_OFF;
    end else begin
      seg_p1 <= seg_nxt;
      dp_p1  <= dp_nxt;
      dig_p1 <= dig_nxt;
    end
  end

  assign nSEG = seg_p1;
  assign nDP  = dp_p1;
  assign nDIG = dig_p1;

endmodule
